// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch/decode definitions: fetch word layout, PC step and fetch FSM states.
// Decode imports this package to unpack {instr, pc}.
package instr_fetch_queue_pkg;

    localparam int          FETCH_W   = 64;
    localparam int          INSTR_LSB = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [FETCH_W-1:0] pack_fetch(input logic [31:0] instr,
                                                      input logic [31:0] pc);
        return {instr, pc};
    endfunction

    function automatic logic [31:0] fetch_instr(input logic [FETCH_W-1:0] word);
        return word[FETCH_W-1:INSTR_LSB];
    endfunction

    function automatic logic [31:0] fetch_pc(input logic [FETCH_W-1:0] word);
        return word[INSTR_LSB-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is combinational from storage and reads zero when empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         do_pop;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // The producer's credit scheme must never let a push land on a full queue.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !flush));
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch producer: issues sequential imem reads from req_pc and queues in-order responses for decode.
// A redirect reloads both PCs, flushes the queue and drops responses still owed to the old path.
//
// state   | meaning
// S_BOOT  | first cycle after reset, no request issued
// S_RUN   | normal sequential fetch
// S_DRAIN | old-path responses outstanding (drop_cnt>0), still fetching new path
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [31:0]        imem_resp_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_addr,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [FETCH_W-1:0] fetch_instr_pc
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [31:0]        req_pc;
    logic [31:0]        req_pc_next;
    logic [31:0]        resp_pc;
    logic [31:0]        resp_pc_next;
    logic [31:0]        target_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      inflight_next;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      drop_cnt_next;
    logic [CW-1:0]      count;
    logic [CW:0]        credit_used;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic               flush;
    logic               fifo_empty;
    logic [FETCH_W-1:0] fifo_head;
    logic [1:0]         unused_addr_lsb;

    assign unused_addr_lsb = redirect_addr[1:0];
    assign target_pc       = {redirect_addr[31:2], 2'b00};

    // Queue slots plus outstanding requests never exceed DEPTH, so responses always fit.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = (state != S_BOOT) && (credit_used < DEPTH_C);
    assign imem_req_addr  = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign flush          = redirect && (state != S_BOOT);
    assign push           = imem_resp_valid && !redirect && (drop_cnt == '0);
    assign pop            = fetch_valid && fetch_ready && !redirect;
    assign fetch_valid    = !fifo_empty;
    assign fetch_instr_pc = fifo_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (FETCH_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (pack_fetch(imem_resp_data, resp_pc)),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_comb begin
        state_next    = state;
        req_pc_next   = req_pc;
        resp_pc_next  = resp_pc;
        drop_cnt_next = drop_cnt;
        inflight_next = inflight + CW'(req_fire) - CW'(imem_resp_valid);

        if (redirect) begin
            req_pc_next  = target_pc;
            resp_pc_next = target_pc;
        end else begin
            if (req_fire) begin
                req_pc_next = req_pc + PC_STEP;
            end
            if (push) begin
                resp_pc_next = resp_pc + PC_STEP;
            end
        end

        // Everything still owed after this edge belongs to the abandoned path.
        if (flush) begin
            drop_cnt_next = inflight_next;
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - CW'(1);
        end

        case (state)
            S_BOOT:         state_next = S_RUN;
            S_RUN, S_DRAIN: state_next = (drop_cnt_next != '0) ? S_DRAIN : S_RUN;
            default:        state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            req_pc   <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            req_pc   <= req_pc_next;
            resp_pc  <= resp_pc_next;
            inflight <= inflight_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_resp_valid && (inflight == '0)));
        end
    end

endmodule
